// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory responder
package mem_pkg;

   localparam int WORD_W          = 32;
   localparam int DEF_DEPTH_WORDS = 256;
   localparam int DEF_LATENCY     = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Number of word-index bits for a power-of-two depth.
   function automatic int idx_width(input int depth_words);
      return (depth_words > 1) ? $clog2(depth_words) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - enable-gated single-port RAM, synchronous write and read
module dmem_array
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int AW          = idx_width(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [AW-1:0]     idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   // rdata only moves on an enabled read, so it doubles as the held load result.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[idx] <= wdata;
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with fixed access latency and pipeline stall
module dmem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int LATENCY     = DEF_LATENCY
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              memwrite,
   input  logic              memread,
   input  logic [31:0]       addr,
   input  logic [31:0]       write_data,
   output logic              resp_valid,
   output logic [31:0]       read_data,
   output logic              err,
   output logic              stall
);

   localparam int AW = idx_width(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            resp_load;
   logic            err_q;
   logic            accept;
   logic            fault;
   logic            do_store;
   logic            do_load;
   logic [AW-1:0]   word_idx;
   logic [31:0]     ram_rdata;
   logic            unused_addr_hi;

   assign accept   = !reset && (state == IDLE) && req_valid;
   assign fault    = (memread && memwrite) ||
                     ((memread || memwrite) && (addr[1:0] != 2'b00));
   assign do_store = accept && memwrite && !fault;
   assign do_load  = accept && memread && !fault;
   assign word_idx = addr[AW+1:2];
   assign unused_addr_hi = ^addr[31:AW+2];

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .en    (do_store || do_load),
      .we    (do_store),
      .idx   (word_idx),
      .wdata (write_data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         resp_load <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  resp_load <= do_load;
                  err_q     <= fault;
                  if (LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= CW'(LATENCY - 2);
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign stall      = ((state == IDLE) && req_valid) || (state == WAIT);
   // Faulted, store and no-op responses all report zero data.
   assign read_data  = resp_load ? ram_rdata : 32'd0;
   assign err        = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench over three latency configurations
module tb_dmem_responder;

   typedef struct {
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        memwrite = 1'b0;
   logic        memread = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] write_data = '0;
   logic [1:0]  sel = 2'd0;

   logic [2:0]  rq;
   logic [2:0]  rr;
   logic [2:0]  rv;
   logic [2:0]  er;
   logic [2:0]  st;
   logic [31:0] rd [3];

   logic        o_req_ready, o_resp_valid, o_err, o_stall;
   logic [31:0] o_read_data;

   int          cyc = 0;
   int          checks = 0;
   int          passed = 0;
   int          stall_cnt = 0;
   exp_t        exp_q[$];
   int          acc_q[$];
   logic [31:0] model [3][256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rq           = req_valid ? (3'b001 << sel) : 3'b000;
   assign o_req_ready  = rr[sel];
   assign o_resp_valid = rv[sel];
   assign o_err        = er[sel];
   assign o_stall      = st[sel];
   assign o_read_data  = rd[sel];

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
      .clk(clk), .reset(reset), .req_valid(rq[0]), .req_ready(rr[0]),
      .memwrite(memwrite), .memread(memread), .addr(addr), .write_data(write_data),
      .resp_valid(rv[0]), .read_data(rd[0]), .err(er[0]), .stall(st[0]));

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_lat4 (
      .clk(clk), .reset(reset), .req_valid(rq[1]), .req_ready(rr[1]),
      .memwrite(memwrite), .memread(memread), .addr(addr), .write_data(write_data),
      .resp_valid(rv[1]), .read_data(rd[1]), .err(er[1]), .stall(st[1]));

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_lat1 (
      .clk(clk), .reset(reset), .req_valid(rq[2]), .req_ready(rr[2]),
      .memwrite(memwrite), .memread(memread), .addr(addr), .write_data(write_data),
      .resp_valid(rv[2]), .read_data(rd[2]), .err(er[2]), .stall(st[2]));

   function automatic int lat_of(input logic [1:0] s);
      case (s)
         2'd0:    return 2;
         2'd1:    return 4;
         default: return 1;
      endcase
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) & 32'd255);
   endfunction

   // Response monitor: pops the scoreboard on every resp_valid pulse.
   always @(negedge clk) begin
      exp_t e;
      int   a;
      if (reset) begin
         acc_q.delete();
      end else begin
         if (o_stall) stall_cnt++;
         if (o_resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_resp: resp_valid=1 with no request outstanding at cycle %0d", cyc);
            end else begin
               passed++;
               e = exp_q.pop_front();
               a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
               checks++;
               if (o_read_data !== e.data)
                  $display("FAIL read_data: got %h want %h", o_read_data, e.data);
               else passed++;
               checks++;
               if (o_err !== e.err)
                  $display("FAIL err: got %b want %b", o_err, e.err);
               else passed++;
               checks++;
               if ((cyc - a) != lat_of(sel))
                  $display("FAIL latency: got %0d want %0d", cyc - a, lat_of(sel));
               else passed++;
               checks++;
               if (o_req_ready !== 1'b0 || o_stall !== 1'b0)
                  $display("FAIL resp_flags: req_ready=%b stall=%b want 0 0", o_req_ready, o_stall);
               else passed++;
            end
         end
         if (req_valid && o_req_ready) acc_q.push_back(cyc);
      end
   end

   task automatic issue(input logic [1:0] s, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_e, input logic [31:0] exp_d);
      int   n;
      exp_t e;
      sel = s; memwrite = w; memread = r; addr = a; write_data = d;
      req_valid = 1'b1;
      e.err = exp_e; e.data = exp_d;
      exp_q.push_back(e);
      stall_cnt = 0;
      n = 0;
      while (!o_req_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0; memwrite = 1'b0; memread = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL resp_timeout: %0d responses outstanding want 0", exp_q.size());
         exp_q.delete();
      end else passed++;
   endtask

   task automatic store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      model[s][widx(a)] = d;
      issue(s, 1'b1, 1'b0, a, d, 1'b0, 32'd0);
   endtask

   task automatic load(input logic [1:0] s, input logic [31:0] a);
      issue(s, 1'b0, 1'b1, a, 32'd0, 1'b0, model[s][widx(a)]);
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b1; sel = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (o_resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", o_resp_valid); else passed++;
      checks++; if (o_read_data !== 32'd0) $display("FAIL rst_read_data: got %h want 0", o_read_data); else passed++;
      checks++; if (o_err !== 1'b0) $display("FAIL rst_err: got %b want 0", o_err); else passed++;
      checks++; if (o_req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", o_req_ready); else passed++;
      checks++; if (o_stall !== 1'b1) $display("FAIL rst_stall: got %b want 1", o_stall); else passed++;
      reset = 1'b0; req_valid = 1'b0;
      #1;
      checks++; if (o_stall !== 1'b0) $display("FAIL rel_stall: got %b want 0", o_stall); else passed++;
      @(posedge clk); #1;
      checks++; if (o_req_ready !== 1'b1) $display("FAIL rel_req_ready: got %b want 1", o_req_ready); else passed++;
   endtask

   task automatic test_store_load;
      store(2'd0, 32'h10, 32'hDEADBEEF);
      checks++;
      if (stall_cnt != 2) $display("FAIL store_stall_cycles: got %0d want 2", stall_cnt); else passed++;
      load(2'd0, 32'h10);
   endtask

   task automatic test_wrap;
      store(2'd0, 32'h404, 32'h12345678);
      load(2'd0, 32'h004);
   endtask

   task automatic test_misaligned;
      issue(2'd0, 1'b0, 1'b1, 32'h13, 32'd0, 1'b1, 32'd0);
      issue(2'd0, 1'b1, 1'b0, 32'h11, 32'h11111111, 1'b1, 32'd0);
      load(2'd0, 32'h10);
      load(2'd0, 32'h004);
   endtask

   task automatic test_conflict_noop;
      store(2'd0, 32'h20, 32'h0BADF00D);
      issue(2'd0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 1'b1, 32'd0);
      load(2'd0, 32'h20);
      issue(2'd0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic test_reset_in_wait;
      int pulses;
      sel = 2'd1; memwrite = 1'b1; memread = 1'b0;
      addr = 32'h30; write_data = 32'hA5A5A5A5; req_valid = 1'b1;
      model[1][widx(32'h30)] = 32'hA5A5A5A5;
      @(posedge clk); #1;
      req_valid = 1'b0; memwrite = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (o_req_ready !== 1'b1) $display("FAIL rst_wait_idle: req_ready=%b want 1", o_req_ready); else passed++;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (o_resp_valid) pulses++;
         @(posedge clk); #1;
      end
      checks++;
      if (pulses != 0) $display("FAIL rst_wait_dropped: got %0d pulses want 0", pulses); else passed++;
      load(2'd1, 32'h30);
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   t1, t2, n;
      sel = 2'd2; memwrite = 1'b1; memread = 1'b0;
      addr = 32'h40; write_data = 32'hCAFEF00D; req_valid = 1'b1;
      model[2][widx(32'h40)] = 32'hCAFEF00D;
      e.err = 1'b0; e.data = 32'd0; exp_q.push_back(e);
      @(posedge clk); #1;
      t1 = cyc;
      memwrite = 1'b0; memread = 1'b1;
      e.err = 1'b0; e.data = model[2][widx(32'h40)]; exp_q.push_back(e);
      checks++;
      if (o_resp_valid !== 1'b1 || o_req_ready !== 1'b0)
         $display("FAIL b2b_resp1: resp_valid=%b req_ready=%b want 1 0", o_resp_valid, o_req_ready);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1)
         $display("FAIL b2b_idle: resp_valid=%b req_ready=%b want 0 1", o_resp_valid, o_req_ready);
      else passed++;
      @(posedge clk); #1;
      t2 = cyc;
      req_valid = 1'b0; memread = 1'b0;
      checks++;
      if (t2 - t1 != 2) $display("FAIL b2b_accept_gap: got %0d want 2", t2 - t1); else passed++;
      checks++;
      if (o_resp_valid !== 1'b1 || o_req_ready !== 1'b0)
         $display("FAIL b2b_resp2: resp_valid=%b req_ready=%b want 1 0", o_resp_valid, o_req_ready);
      else passed++;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL b2b_drain: %0d responses outstanding want 0", exp_q.size());
         exp_q.delete();
      end else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_store_load();
      test_wrap();
      test_misaligned();
      test_conflict_noop();
      test_reset_in_wait();
      test_back_to_back();
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
